cpu_sequencer: RTL

- Multi-cycle control sequencer for the 8-bit accumulator core: program memory (32 x 6-bit), instruction_decoder, 4-entry register file, ALU, accumulator.
- Replaces the free-running program counter. Owns the PC and an instruction register (IR), and steps each instruction through FETCH/DECODE/EXECUTE/WRITEBACK.
- Gates the decoder's RF/ALU/accumulator clock enables so each fires in exactly one phase.
- Adds run/single-step/halt control and a retired-instruction counter.

---
 rtl/cpu_seq_pkg.sv | 19 +
 rtl/seq_pc.sv | 40 ++++
 rtl/cpu_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the multi-cycle accumulator-core sequencer.
// Included by the sequencer top and its PC sub-block.
package cpu_seq_pkg;

  localparam int ADDR_W  = 5;
  localparam int INSTR_W = 6;

  localparam logic [INSTR_W-1:0] HALT_INSTR = 6'b111111;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALTED    = 3'd5
  } seq_state_t;

endpackage

// File: rtl/seq_pc.sv
// Program counter: increment with wrap at PROG_LEN-1, synchronous clear,
// asynchronous active-low reset.
module seq_pc
  import cpu_seq_pkg::*;
#(
  parameter int PROG_LEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Clear has priority so a restart can never be overridden by a stale increment.
  always_comb begin
    pc_d = pc_q;
    if (clr_i) begin
      pc_d = '0;
    end else if (inc_i) begin
      pc_d = (pc_q == LAST_PC) ? '0 : pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the accumulator core:
// owns PC and IR, gates decoder enables to one phase each, adds run/step/halt control.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int PROG_LEN = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               step,
  input  logic               restart,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               dec_RF_ce,
  input  logic               dec_ALU_ce,
  input  logic               dec_A_ce,
  output logic [ADDR_W-1:0]  instruction_address,
  output logic [INSTR_W-1:0] instruction_reg,
  output logic               RF_ce,
  output logic               ALU_ce,
  output logic               A_ce,
  output logic               busy,
  output logic               halted,
  output logic [7:0]         instr_count,
  output seq_state_t         dbg_state
);

  seq_state_t         state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               rf_lat_q, rf_lat_d;
  logic               alu_lat_q, alu_lat_d;
  logic               a_lat_q, a_lat_d;
  logic               oneshot_q, oneshot_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               rf_ce_q, rf_ce_d;
  logic               alu_ce_q, alu_ce_d;
  logic               a_ce_q, a_ce_d;
  logic               pc_inc;
  logic               pc_clr;
  logic [ADDR_W-1:0]  pc;

  seq_pc #(
    .PROG_LEN (PROG_LEN)
  ) u_pc (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (pc_clr),
    .inc_i (pc_inc),
    .pc_o  (pc)
  );

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    rf_lat_d  = rf_lat_q;
    alu_lat_d = alu_lat_q;
    a_lat_d   = a_lat_q;
    oneshot_d = oneshot_q;
    cnt_d     = cnt_q;
    pc_inc    = 1'b0;
    pc_clr    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // run outranks step, so a simultaneous step never arms the one-shot.
        if (run) begin
          state_d   = S_FETCH;
          oneshot_d = 1'b0;
        end else if (step) begin
          state_d   = S_FETCH;
          oneshot_d = 1'b1;
        end
      end
      S_FETCH: begin
        ir_d    = instruction;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (ir_q == HALT_INSTR) begin
          state_d = S_HALTED;
        end else begin
          rf_lat_d  = dec_RF_ce;
          alu_lat_d = dec_ALU_ce;
          a_lat_d   = dec_A_ce;
          state_d   = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        pc_inc = 1'b1;
        cnt_d  = cnt_q + 8'd1;
        if (run && !oneshot_q) begin
          state_d = S_FETCH;
        end else begin
          state_d   = S_IDLE;
          oneshot_d = 1'b0;
        end
      end
      S_HALTED: begin
        if (restart) begin
          state_d = S_IDLE;
          pc_clr  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Enables are flopped from the next state so each is a clean one-cycle pulse.
  always_comb begin
    rf_ce_d  = (state_d == S_EXECUTE) && rf_lat_d;
    alu_ce_d = (state_d == S_EXECUTE) && alu_lat_d;
    a_ce_d   = (state_d == S_WRITEBACK) && a_lat_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      rf_lat_q  <= 1'b0;
      alu_lat_q <= 1'b0;
      a_lat_q   <= 1'b0;
      oneshot_q <= 1'b0;
      cnt_q     <= 8'd0;
      rf_ce_q   <= 1'b0;
      alu_ce_q  <= 1'b0;
      a_ce_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      rf_lat_q  <= rf_lat_d;
      alu_lat_q <= alu_lat_d;
      a_lat_q   <= a_lat_d;
      oneshot_q <= oneshot_d;
      cnt_q     <= cnt_d;
      rf_ce_q   <= rf_ce_d;
      alu_ce_q  <= alu_ce_d;
      a_ce_q    <= a_ce_d;
    end
  end

  assign instruction_address = pc;
  assign instruction_reg     = ir_q;
  assign RF_ce               = rf_ce_q;
  assign ALU_ce              = alu_ce_q;
  assign A_ce                = a_ce_q;
  assign busy                = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                               (state_q == S_EXECUTE) || (state_q == S_WRITEBACK);
  assign halted              = (state_q == S_HALTED);
  assign instr_count         = cnt_q;
  assign dbg_state           = state_q;

endmodule
